// File: rtl/dma_write_pkg.sv
// Shared types for the device-to-host DMA write engine.
// Provides the FSM state enum, the MPS decode function and fixed AXI4 read attributes.
package dma_write_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_AR,
      S_RDATA,
      S_REQ,
      S_DATA
   } state_e;

   localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [3:0]  AXI_CACHE_MOD  = 4'b0011;
   localparam logic [2:0]  AXI_PROT       = 3'b000;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam logic [12:0] PAGE_BYTES     = 13'd4096;

   // PCIe max payload size code to bytes; reserved codes fall back to 128.
   function automatic logic [12:0] mps_bytes(input logic [2:0] code);
      logic [12:0] b;
      unique case (code)
         3'b000:  b = 13'd128;
         3'b001:  b = 13'd256;
         3'b010:  b = 13'd512;
         3'b011:  b = 13'd1024;
         3'b100:  b = 13'd2048;
         3'b101:  b = 13'd4096;
         default: b = 13'd128;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dma_write_controller_fifo.sv
// Show-ahead beat buffer: rdata_o always presents the oldest entry.
// Ports: clk_i, rst_i (async, active-high), push_i/wdata_i, pop_i/rdata_o, empty_o, count_o.
module dma_write_controller_fifo #(
   parameter int BITS_WIDTH = 128,
   parameter int BITS_DEPTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [BITS_WIDTH-1:0] wdata_i,
   input  logic                  pop_i,
   output logic [BITS_WIDTH-1:0] rdata_o,
   output logic                  empty_o,
   output logic [BITS_DEPTH:0]   count_o
);

   localparam int DEPTH = 1 << BITS_DEPTH;

   logic [BITS_WIDTH-1:0] mem_q [DEPTH];
   logic [BITS_DEPTH-1:0] wptr_q;
   logic [BITS_DEPTH-1:0] rptr_q;
   logic [BITS_DEPTH:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push_i && (count_q != (BITS_DEPTH+1)'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{BITS_DEPTH{1'b0}}, do_push}
                            - {{BITS_DEPTH{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/dma_write_controller.sv
// Device-to-host DMA: splits a transfer into PCIe-legal chunks, reads each chunk
// with one AXI4 burst and streams it out as a memory-write header plus 128-bit data.
// Ports: descriptor/start/busy/done/error, AXI4 AR+R master, PCIe TX header and data streams.
module dma_write_controller
   import dma_write_pkg::*;
#(
   parameter int p_buf_bits = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [15:0]  pcie_dcommand,
   input  logic [31:0]  dma_write_host_address,
   input  logic [31:0]  dma_write_device_address,
   input  logic [31:0]  dma_write_length,
   input  logic         dma_write_start,
   output logic         dma_write_busy,
   output logic         dma_write_done,
   output logic         dma_write_error,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic [3:0]   arcache,
   output logic [2:0]   arprot,
   output logic         arvalid,
   input  logic         arready,
   input  logic [127:0] rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [31:0]  dma_write_addr,
   output logic [9:0]   dma_write_len,
   output logic         dma_write_valid,
   input  logic         dma_write_ready,
   output logic [127:0] dma_write_data,
   output logic         dma_write_data_valid,
   output logic         dma_write_data_last,
   input  logic         dma_write_data_ready
);

   localparam int CW = p_buf_bits + 1;

   state_e      state_q, state_d;
   logic [31:0] host_q, host_d;
   logic [31:0] dev_q, dev_d;
   logic [31:0] rem_q, rem_d;
   logic [12:0] chunk_q, chunk_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic [31:0] addr_q, addr_d;
   logic [9:0]  len_q, len_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [12:0] rem_cap, host_room, dev_room, mps;
   logic [12:0] min_a, min_b, chunk_c;
   logic        push, pop, empty;
   logic [CW-1:0] count;
   logic [127:0]  buf_rdata;
   logic          unused_ok;

   // Chunk = min(remaining, MPS, bytes to host 4K, bytes to device 4K).
   assign rem_cap   = (rem_q > 32'd4096) ? PAGE_BYTES : rem_q[12:0];
   assign host_room = PAGE_BYTES - {1'b0, host_q[11:0]};
   assign dev_room  = PAGE_BYTES - {1'b0, dev_q[11:0]};
   assign mps       = mps_bytes(pcie_dcommand[7:5]);
   assign min_a     = (rem_cap < mps) ? rem_cap : mps;
   assign min_b     = (host_room < dev_room) ? host_room : dev_room;
   assign chunk_c   = (min_a < min_b) ? min_a : min_b;

   assign arsize  = AXI_SIZE_16B;
   assign arburst = AXI_BURST_INCR;
   assign arcache = AXI_CACHE_MOD;
   assign arprot  = AXI_PROT;

   assign arvalid         = (state_q == S_AR);
   assign rready          = (state_q == S_RDATA);
   assign dma_write_valid = (state_q == S_REQ);
   assign dma_write_busy  = (state_q != S_IDLE);
   assign dma_write_done  = done_q;
   assign dma_write_error = err_q;
   assign araddr          = araddr_q;
   assign arlen           = arlen_q;
   assign dma_write_addr  = addr_q;
   assign dma_write_len   = len_q;

   // The buffer holds exactly one chunk, so the last entry is the last beat.
   assign dma_write_data       = buf_rdata;
   assign dma_write_data_valid = (state_q == S_DATA) && !empty;
   assign dma_write_data_last  = dma_write_data_valid && (count == CW'(1));

   assign push = rready && rvalid;
   assign pop  = dma_write_data_valid && dma_write_data_ready;

   assign unused_ok = ^{pcie_dcommand[15:8], pcie_dcommand[4:0],
                        dma_write_host_address[3:0],
                        dma_write_device_address[3:0],
                        dma_write_length[3:0]};

   dma_write_controller_fifo #(
      .BITS_WIDTH(128),
      .BITS_DEPTH(p_buf_bits)
   ) u_buf (
      .clk_i   (i_clk),
      .rst_i   (!i_rst_n),
      .push_i  (push),
      .wdata_i (rdata),
      .pop_i   (pop),
      .rdata_o (buf_rdata),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         host_q   <= '0;
         dev_q    <= '0;
         rem_q    <= '0;
         chunk_q  <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         host_q   <= host_d;
         dev_q    <= dev_d;
         rem_q    <= rem_d;
         chunk_q  <= chunk_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      host_d   = host_q;
      dev_d    = dev_q;
      rem_d    = rem_q;
      chunk_d  = chunk_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      addr_d   = addr_q;
      len_d    = len_q;
      err_d    = err_q;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dma_write_start) begin
               host_d = {dma_write_host_address[31:4], 4'h0};
               dev_d  = {dma_write_device_address[31:4], 4'h0};
               rem_d  = {dma_write_length[31:4], 4'h0};
               err_d  = 1'b0;
               if (dma_write_length[31:4] == '0) done_d  = 1'b1;
               else                              state_d = S_CALC;
            end
         end
         S_CALC: begin
            chunk_d  = chunk_c;
            araddr_d = dev_q;
            // 4096 B wraps to 0 in both fields: arlen 255, len 0 (=1024 DW).
            arlen_d  = chunk_c[11:4] - 8'd1;
            addr_d   = host_q;
            len_d    = chunk_c[11:2];
            state_d  = S_AR;
         end
         S_AR: begin
            if (arready) state_d = S_RDATA;
         end
         S_RDATA: begin
            if (rvalid) begin
               if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
               if (rlast) state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dma_write_ready) state_d = S_DATA;
         end
         S_DATA: begin
            if (pop && dma_write_data_last) begin
               host_d = host_q + {19'd0, chunk_q};
               dev_d  = dev_q + {19'd0, chunk_q};
               rem_d  = rem_q - {19'd0, chunk_q};
               if (rem_q == {19'd0, chunk_q}) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_write_controller.sv
// Testbench for dma_write_controller: AXI read slave, PCIe TX sink and a
// chunk-list reference model built from the transfer rules.
module tb_dma_write_controller;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic [15:0]  pcie_dcommand;
   logic [31:0]  dma_write_host_address;
   logic [31:0]  dma_write_device_address;
   logic [31:0]  dma_write_length;
   logic         dma_write_start;
   logic         dma_write_busy;
   logic         dma_write_done;
   logic         dma_write_error;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [127:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [31:0]  dma_write_addr;
   logic [9:0]   dma_write_len;
   logic         dma_write_valid;
   logic         dma_write_ready;
   logic [127:0] dma_write_data;
   logic         dma_write_data_valid;
   logic         dma_write_data_last;
   logic         dma_write_data_ready;

   always #5 i_clk = ~i_clk;

   dma_write_controller #(.p_buf_bits(8)) dut (
      .i_clk                    (i_clk),
      .i_rst_n                  (i_rst_n),
      .pcie_dcommand            (pcie_dcommand),
      .dma_write_host_address   (dma_write_host_address),
      .dma_write_device_address (dma_write_device_address),
      .dma_write_length         (dma_write_length),
      .dma_write_start          (dma_write_start),
      .dma_write_busy           (dma_write_busy),
      .dma_write_done           (dma_write_done),
      .dma_write_error          (dma_write_error),
      .araddr                   (araddr),
      .arlen                    (arlen),
      .arsize                   (arsize),
      .arburst                  (arburst),
      .arcache                  (arcache),
      .arprot                   (arprot),
      .arvalid                  (arvalid),
      .arready                  (arready),
      .rdata                    (rdata),
      .rresp                    (rresp),
      .rlast                    (rlast),
      .rvalid                   (rvalid),
      .rready                   (rready),
      .dma_write_addr           (dma_write_addr),
      .dma_write_len            (dma_write_len),
      .dma_write_valid          (dma_write_valid),
      .dma_write_ready          (dma_write_ready),
      .dma_write_data           (dma_write_data),
      .dma_write_data_valid     (dma_write_data_valid),
      .dma_write_data_last      (dma_write_data_last),
      .dma_write_data_ready     (dma_write_data_ready)
   );

   int checks = 0;
   int errors = 0;
   int ar_delay = 0;
   int hdr_delay = 0;
   bit dready_rand = 0;
   int err_beat = -1;
   int rbeat_idx = 0;
   int done_cnt = 0;
   int arv_cnt = 0;
   int stall_bad = 0;
   bit prev_stall = 0;
   logic [127:0] prev_data;
   logic prev_last;

   logic [39:0]  ar_log[$];
   logic [41:0]  hdr_log[$];
   logic [128:0] beat_log[$];
   logic [31:0]  exp_h[$];
   logic [31:0]  exp_d[$];
   int           exp_c[$];

   function automatic logic [127:0] mem_word(input logic [31:0] a);
      return {a, a ^ 32'hA5A5_5A5A, ~a, a * 32'd7 + 32'd1};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build_model(input logic [31:0] h, input logic [31:0] d,
                              input logic [31:0] l, input logic [2:0] code);
      int mps;
      int c;
      int room;
      logic [31:0] hh, dd, rem;
      exp_h.delete();
      exp_d.delete();
      exp_c.delete();
      mps = (code <= 3'd5) ? (128 << code) : 128;
      hh  = h & ~32'hF;
      dd  = d & ~32'hF;
      rem = l & ~32'hF;
      while (rem != 0) begin
         c = (rem > 32'(mps)) ? mps : int'(rem);
         room = 4096 - int'(hh % 32'd4096);
         if (room < c) c = room;
         room = 4096 - int'(dd % 32'd4096);
         if (room < c) c = room;
         exp_h.push_back(hh);
         exp_d.push_back(dd);
         exp_c.push_back(c);
         hh  = hh + 32'(c);
         dd  = dd + 32'(c);
         rem = rem - 32'(c);
      end
   endtask

   task automatic clear_logs();
      ar_log.delete();
      hdr_log.delete();
      beat_log.delete();
      done_cnt  = 0;
      stall_bad = 0;
      rbeat_idx = 0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, " done timeout"}, 128'(n < 20000), 128'(1));
   endtask

   task automatic compare_logs(input string tag);
      int k;
      int nb;
      k = 0;
      check({tag, " ar count"}, 128'(ar_log.size()), 128'(exp_c.size()));
      check({tag, " hdr count"}, 128'(hdr_log.size()), 128'(exp_c.size()));
      for (int i = 0; i < exp_c.size(); i++) begin
         nb = exp_c[i] / 16;
         if (i < ar_log.size()) begin
            check({tag, " araddr"}, 128'(ar_log[i][39:8]), 128'(exp_d[i]));
            check({tag, " arlen"}, 128'(ar_log[i][7:0]), 128'(nb - 1));
         end
         if (i < hdr_log.size()) begin
            check({tag, " hdr addr"}, 128'(hdr_log[i][41:10]), 128'(exp_h[i]));
            check({tag, " hdr len"}, 128'(hdr_log[i][9:0]),
                  128'((exp_c[i] / 4) % 1024));
         end
         for (int j = 0; j < nb; j++) begin
            if (k < beat_log.size()) begin
               check({tag, " data"}, beat_log[k][127:0],
                     mem_word(exp_d[i] + 32'(16 * j)));
               check({tag, " last"}, 128'(beat_log[k][128]), 128'(j == nb - 1));
            end
            k++;
         end
      end
      check({tag, " beat count"}, 128'(beat_log.size()), 128'(k));
      check({tag, " stall stable"}, 128'(stall_bad), 128'(0));
   endtask

   task automatic run_xfer(input string tag, input logic [31:0] h,
                           input logic [31:0] d, input logic [31:0] l,
                           input logic [2:0] code, input bit exp_err,
                           input bit poke);
      build_model(h, d, l, code);
      clear_logs();
      pcie_dcommand = 16'($urandom);
      pcie_dcommand[7:5] = code;
      dma_write_host_address = h;
      dma_write_device_address = d;
      dma_write_length = l;
      @(negedge i_clk);
      dma_write_start = 1'b1;
      @(negedge i_clk);
      dma_write_start = 1'b0;
      check({tag, " busy after start"}, 128'(dma_write_busy), 128'(1));
      @(negedge i_clk);
      check({tag, " arvalid N+2"}, 128'(arvalid), 128'(1));
      if (poke) begin
         repeat (3) @(negedge i_clk);
         dma_write_host_address = 32'h9000;
         dma_write_device_address = 32'h0;
         dma_write_length = 32'd64;
         dma_write_start = 1'b1;
         @(negedge i_clk);
         dma_write_start = 1'b0;
      end
      wait_done(tag);
      check({tag, " busy low at done"}, 128'(dma_write_busy), 128'(0));
      repeat (2) @(negedge i_clk);
      check({tag, " done pulses"}, 128'(done_cnt), 128'(1));
      check({tag, " error"}, 128'(dma_write_error), 128'(exp_err));
      compare_logs(tag);
   endtask

   // AXI4 read slave: serves bursts from mem_word(address).
   initial begin : axi_slave
      logic [31:0] a;
      logic [7:0]  n;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      rdata   = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst_n && arvalid) begin
            repeat (ar_delay) @(negedge i_clk);
            a = araddr;
            n = arlen;
            ar_log.push_back({a, n});
            arready = 1'b1;
            @(negedge i_clk);
            arready = 1'b0;
            for (int b = 0; b <= int'(n); b++) begin
               rvalid = 1'b1;
               rdata  = mem_word(a + 32'(16 * b));
               rlast  = (b == int'(n));
               rresp  = (rbeat_idx == err_beat) ? 2'b10 : 2'b00;
               rbeat_idx++;
               @(negedge i_clk);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
         end
      end
   end

   // PCIe header sink.
   initial begin : hdr_sink
      dma_write_ready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_rst_n && dma_write_valid) begin
            repeat (hdr_delay) @(negedge i_clk);
            hdr_log.push_back({dma_write_addr, dma_write_len});
            dma_write_ready = 1'b1;
            @(negedge i_clk);
            dma_write_ready = 1'b0;
         end
      end
   end

   // PCIe data sink; also watches that stalled beats stay stable.
   initial begin : data_sink
      dma_write_data_ready = 1'b0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            dma_write_data_ready = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !(dma_write_data_valid &&
                                dma_write_data === prev_data &&
                                dma_write_data_last === prev_last))
               stall_bad++;
            dma_write_data_ready = dready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dma_write_data_valid && dma_write_data_ready)
               beat_log.push_back({dma_write_data_last, dma_write_data});
            prev_stall = dma_write_data_valid && !dma_write_data_ready;
            prev_data  = dma_write_data;
            prev_last  = dma_write_data_last;
         end
      end
   end

   always @(negedge i_clk) begin
      if (dma_write_done) done_cnt++;
      if (arvalid) arv_cnt++;
   end

   initial begin : main
      int a0;
      int n;
      logic [31:0] rh, rd, rl;
      logic [2:0]  rc;
      i_rst_n = 1'b0;
      dma_write_start = 1'b0;
      pcie_dcommand = '0;
      dma_write_host_address = '0;
      dma_write_device_address = '0;
      dma_write_length = '0;
      repeat (3) @(negedge i_clk);
      check("reset outputs",
            128'({arvalid, rready, dma_write_busy, dma_write_done,
                  dma_write_error, dma_write_valid, dma_write_data_valid,
                  dma_write_data_last, dma_write_addr, dma_write_len,
                  araddr, arlen}), 128'(0));
      check("fixed ar attrs", 128'({arsize, arburst, arcache, arprot}),
            128'({3'b100, 2'b01, 4'b0011, 3'b000}));
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);

      run_xfer("mps256", 32'h1000, 32'h0, 32'd1024, 3'b001, 1'b0, 1'b0);
      run_xfer("cross4k", 32'h0FC0, 32'h2000, 32'd256, 3'b010, 1'b0, 1'b0);
      run_xfer("mps4096", 32'h0, 32'h0, 32'd4096, 3'b101, 1'b0, 1'b0);

      ar_delay = 5;
      hdr_delay = 3;
      dready_rand = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rh = $urandom;
         rd = $urandom;
         rl = 32'($urandom_range(16, 6000));
         rc = 3'($urandom_range(0, 7));
         run_xfer("random bp", rh, rd, rl, rc, 1'b0, 1'b0);
      end
      ar_delay = 0;
      hdr_delay = 0;
      dready_rand = 1'b0;

      err_beat = 2;
      run_xfer("rresp err", 32'h4000, 32'h800, 32'd512, 3'b001, 1'b1, 1'b0);
      err_beat = -1;

      // Length below one beat: immediate done, no AXI traffic, error cleared.
      a0 = arv_cnt;
      dma_write_length = 32'h0000_000C;
      @(negedge i_clk);
      dma_write_start = 1'b1;
      @(negedge i_clk);
      dma_write_start = 1'b0;
      check("len0 done", 128'(dma_write_done), 128'(1));
      check("len0 busy", 128'(dma_write_busy), 128'(0));
      check("len0 err clear", 128'(dma_write_error), 128'(0));
      @(negedge i_clk);
      check("len0 done pulse", 128'(dma_write_done), 128'(0));
      check("len0 no arvalid", 128'(arv_cnt), 128'(a0));

      run_xfer("start busy", 32'h2000, 32'h300, 32'd768, 3'b011, 1'b0, 1'b1);

      // Reset in the middle of the data phase.
      clear_logs();
      pcie_dcommand = 16'h0020;
      dma_write_host_address = 32'h3000;
      dma_write_device_address = 32'h500;
      dma_write_length = 32'd512;
      @(negedge i_clk);
      dma_write_start = 1'b1;
      @(negedge i_clk);
      dma_write_start = 1'b0;
      n = 0;
      while (!dma_write_data_valid && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      check("rst data phase reached", 128'(dma_write_data_valid), 128'(1));
      repeat (3) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("rst mid-data outputs",
            128'({arvalid, rready, dma_write_busy, dma_write_done,
                  dma_write_error, dma_write_valid, dma_write_data_valid,
                  dma_write_data_last, dma_write_addr, dma_write_len,
                  araddr, arlen}), 128'(0));
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      clear_logs();
      @(negedge i_clk);
      run_xfer("after rst", 32'h7F80, 32'h1F40, 32'd1536, 3'b100, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_write_controller.md
# dma_write_controller

Device-to-host DMA engine: the write-direction counterpart of the read controller. Takes a host address, device address and byte length, splits the transfer into PCIe-legal chunks, fetches each chunk from device memory with one AXI4 read burst, and streams it to the PCIe TX engine as a memory-write request with a header handshake and a 128-bit data stream. Sits between the config/register block and the AXI interconnect on the device side, and the TLP transmit path on the host side.

## Interface
- p_buf_bits, 8, log2 depth of the 128-bit beat buffer; must be ≥ 8 so one 4 KiB burst always fits
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- pcie_dcommand  in  16  PCIe device control; [7:5] is the max payload size (MPS)
- dma_write_host_address / dma_write_device_address / dma_write_length  in  32 each  transfer descriptor; byte units, bits [3:0] treated as 0
- dma_write_start  in  1  single-cycle start pulse
- dma_write_busy  out  1  high from an accepted start until done
- dma_write_done  out  1  one-cycle pulse at end of transfer
- dma_write_error  out  1  sticky: some rresp ≠ OKAY; cleared on the next accepted start
- araddr  out  32; arlen  out  8; arsize  out  3 (fixed 3'b100); arburst  out  2 (fixed 2'b01); arcache  out  4 (fixed 4'b0011); arprot  out  3 (fixed 0); arvalid  out  1; arready  in  1
- rdata  in  128; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- dma_write_addr  out  32  host address of the current chunk
- dma_write_len  out  10  chunk length in DW; 1024 DW encodes as 0
- dma_write_valid  out  1; dma_write_ready  in  1  header handshake
- dma_write_data  out  128; dma_write_data_valid  out  1; dma_write_data_last  out  1; dma_write_data_ready  in  1

## Operation
- FSM states: IDLE, CALC, AR, RDATA, REQ, DATA.
- IDLE: on dma_write_start, latch the descriptor, clear error, assert busy, and go to CALC. If length[31:4] == 0, skip the transfer: pulse done on the next cycle and stay in IDLE. A start while busy is ignored.
- CALC: chunk = min(remaining, MPS, 4096 − host[11:0], 4096 − dev[11:0]).
  - MPS decode: 000→128, 001→256, 010→512, 011→1024, 100→2048, 101→4096, others→128.
  - All widths are 13 bits.
- AR: araddr = dev, arlen = chunk/16 − 1; hold arvalid until arready.
- RDATA: rready = 1 throughout. Push each beat into the buffer. Any rresp ≠ 00 sets error; the data is still forwarded. rlast moves the FSM to REQ.
- REQ: present the address and len = chunk/4 (modulo 1024); hold valid until ready.
- DATA: pop the buffer onto the data stream with valid/ready; last marks the final beat.
- After the last beat handshake: host += chunk, dev += chunk, remaining −= chunk.
  - remaining == 0 → done pulse, busy low, go to IDLE.
  - Otherwise → CALC.
- pcie_dcommand is sampled in CALC, so an MPS change takes effect at the next chunk.

## Timing
- Reset values:
  - all valids, rready, busy, done, error = 0
  - addr/len/araddr/arlen = 0
  - FSM = IDLE, buffer empty
- Reset is effective immediately, including mid-burst. The interconnect is reset together with this block, so stale R beats are not handled.
- Cycle sequence:
  - start sampled at edge N → CALC during N+1 → arvalid high from N+2.
  - AR handshake at edge M → rready high from M+1.
  - rlast beat at edge K → dma_write_valid from K+1.
  - header handshake at edge H → dma_write_data_valid from H+1 (buffer read latency absorbed).
  - Final data beat at edge D → next CALC, or done pulse, at D+1.
- Data-stream stalls (ready low) hold data/valid/last stable.
- At most one chunk in flight. The AR, R, header and data phases never overlap.

## Structure
- Shared package dma_write_pkg contains:
  - state enum
  - MPS decode function
  - AXI constants (size 16 B, INCR, cache 0011, OKAY)
- Beat buffer: the codebase fifo module, BITS_WIDTH 128, BITS_DEPTH p_buf_bits, with reset driven by !i_rst_n.
- The chunk arithmetic stays inline; no separate splitter module.

## Test plan
- MPS 256, host 0x1000, dev 0x0, len 1024 → 4 chunks:
  - each with arlen 15 and dma_write_len 64
  - host addrs 0x1000/0x1100/0x1200/0x1300
  - one done pulse, then busy low
- Host 4 KiB crossing: MPS 512, host 0x0FC0, len 256 → chunk 64 B (len 16, arlen 3) then 192 B at 0x1000.
- MPS 4096, host 0x0, dev 0x0, len 4096 → arlen 255, dma_write_len 0, 256 data beats, last on beat 256.
- Backpressure:
  - arready delayed 5 cycles, dma_write_ready delayed 3 cycles
  - dma_write_data_ready toggling 50 %
  - → data order is preserved, and no beat is lost or duplicated.
- Error and reset:
  - rresp 2'b10 on beat 2 → error set and the transfer completes; the next start clears error.
  - i_rst_n low mid-DATA → all outputs return to reset values in the same cycle.
- len 0 → done 1 cycle after start, no arvalid; a second start while busy → ignored.
